// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready handshakes: single-cycle logic/arith ops plus
// iterative shift-add multiply and restoring divide (fixed WIDTH-step latency).
module alu_mc #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALU_control_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALU_result,
  output logic             zero
);

  localparam int unsigned ShW  = $clog2(WIDTH);
  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]  hi_q, hi_d;
  logic [WIDTH-1:0]  lo_q, lo_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [1:0]        op_q, op_d;
  logic [WIDTH-1:0]  result_q, result_d;
  logic              zero_q, zero_d;

  logic [ShW-1:0]    shamt;
  logic [WIDTH-1:0]  single_res;
  logic [WIDTH:0]    mul_sum;
  logic [WIDTH:0]    div_shift;
  logic [WIDTH:0]    div_diff;
  logic              div_ge;
  logic [WIDTH-1:0]  hi_step, lo_step;

  // Single-cycle datapath operates directly on the inputs at the acceptance edge.
  always_comb begin
    shamt      = B[ShW-1:0];
    single_res = A;
    case (ALU_control_in)
      4'b0011: single_res = A + B;
      4'b0010: single_res = A - B;
      4'b0001: single_res = A << shamt;
      4'b0110: single_res = A ^ B;
      4'b0111: single_res = A >> shamt;
      4'b1001: single_res = A | B;
      4'b1010: single_res = A & B;
      4'b0100: single_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      4'b0101: single_res = {{(WIDTH-1){1'b0}}, (A < B)};
      4'b1000: single_res = WIDTH'($signed(A) >>> shamt);
      default: single_res = A;
    endcase
  end

  // One iteration step. mul: hi:lo is the running product, multiplier bits consumed
  // from lo[0]. div: hi is the partial remainder, lo shifts dividend out / quotient in.
  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    div_shift = {hi_q, lo_q[WIDTH-1]};
    div_ge    = div_shift >= {1'b0, b_q};
    div_diff  = div_shift - {1'b0, b_q};
    if (!op_q[1]) begin
      hi_step = mul_sum[WIDTH:1];
      lo_step = {mul_sum[0], lo_q[WIDTH-1:1]};
    end else begin
      hi_step = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
      lo_step = {lo_q[WIDTH-2:0], div_ge};
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    b_d      = b_q;
    op_d     = op_q;
    result_d = result_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          if (ALU_control_in[3:2] == 2'b11) begin
            state_d = StBusy;
            cnt_d   = CntW'(WIDTH);
            hi_d    = '0;
            lo_d    = A;
            b_d     = B;
            op_d    = ALU_control_in[1:0];
          end else begin
            state_d  = StDone;
            result_d = single_res;
          end
        end
      end
      StBusy: begin
        hi_d  = hi_step;
        lo_d  = lo_step;
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          state_d  = StDone;
          // mulhu and remu take the high half; mul and divu the low half.
          result_d = op_q[0] ? hi_step : lo_step;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    zero_d = (result_d == '0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      b_q      <= '0;
      op_q     <= '0;
      result_q <= '0;
      zero_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      b_q      <= b_d;
      op_q     <= op_d;
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

  assign in_ready   = (state_q == StIdle);
  assign out_valid  = (state_q == StDone);
  assign ALU_result = result_q;
  assign zero       = zero_q;

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc: directed vectors, random ops against a
// behavioural model, backpressure and mid-operation reset.
module tb_alu_mc;

  localparam int W = 32;

  logic          clk;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  op_a;
  logic [W-1:0]  op_b;
  logic [3:0]    alu_ctrl;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  alu_result;
  logic          zero;

  int n_checks = 0;
  int n_errors = 0;

  alu_mc #(.WIDTH(W)) dut (
    .clk            (clk),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .A              (op_a),
    .B              (op_b),
    .ALU_control_in (alu_ctrl),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .ALU_result     (alu_result),
    .zero           (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_alu(input logic [3:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    logic [4:0]  sh;
    logic [63:0] p;
    sh = b[4:0];
    p  = {32'b0, a} * {32'b0, b};
    case (op)
      4'b0011: return a + b;
      4'b0010: return a - b;
      4'b0001: return a << sh;
      4'b0110: return a ^ b;
      4'b0111: return a >> sh;
      4'b1001: return a | b;
      4'b1010: return a & b;
      4'b0100: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b0101: return (a < b) ? 32'd1 : 32'd0;
      4'b1000: return W'($signed(a) >>> sh);
      4'b1100: return p[31:0];
      4'b1101: return p[63:32];
      4'b1110: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      4'b1111: return (b == 0) ? a : a % b;
      default: return a;
    endcase
  endfunction

  // Called #1 after a rising edge with the DUT idle. Presents one request,
  // scrambles inputs once accepted, measures latency, then holds out_ready low
  // for bp cycles while offering ignored requests.
  task automatic do_op(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input int bp);
    logic [W-1:0] exp_res;
    int           exp_lat;
    int           lat;
    int           rdy_bad;
    exp_res = ref_alu(op, a, b);
    exp_lat = (op[3:2] == 2'b11) ? W + 1 : 1;
    in_valid = 1'b1;
    op_a     = a;
    op_b     = b;
    alu_ctrl = op;
    @(posedge clk); #1;
    in_valid = 1'b0;
    op_a     = $urandom;
    op_b     = $urandom;
    alu_ctrl = 4'($urandom);
    lat      = 1;
    rdy_bad  = 0;
    while (!out_valid && lat < 200) begin
      if (in_ready) rdy_bad++;
      in_valid = $urandom_range(0, 1) == 1;
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 1'b0;
    check({tag, ".lat"}, 64'(lat), 64'(exp_lat));
    check({tag, ".busy_rdy"}, 64'(rdy_bad), 64'd0);
    check({tag, ".res"}, 64'(alu_result), 64'(exp_res));
    check({tag, ".zero"}, 64'(zero), 64'(exp_res == 0));
    for (int i = 0; i < bp; i++) begin
      in_valid = 1'b1;
      op_a     = $urandom;
      alu_ctrl = 4'($urandom);
      @(posedge clk); #1;
      check({tag, ".bp_res"}, 64'(alu_result), 64'(exp_res));
      check({tag, ".bp_ov"}, 64'(out_valid), 64'd1);
      check({tag, ".bp_rdy"}, 64'(in_ready), 64'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, ".ret_ov"}, 64'(out_valid), 64'd0);
    check({tag, ".ret_rdy"}, 64'(in_ready), 64'd1);
  endtask

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return W'($urandom_range(0, 20));
      3:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    reset     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    op_a      = '0;
    op_b      = '0;
    alu_ctrl  = '0;
    #12;
    check("rst.ov", 64'(out_valid), 64'd0);
    check("rst.res", 64'(alu_result), 64'd0);
    check("rst.zero", 64'(zero), 64'd1);
    check("rst.rdy", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    do_op("v1_add", 4'b0011, 32'h7FFF_FFFF, 32'd1, 0);
    do_op("v1_sub", 4'b0010, 32'd5, 32'd5, 0);
    do_op("v2_sra", 4'b1000, 32'h8000_0000, 32'h21, 0);
    do_op("v2_srl", 4'b0111, 32'h8000_0000, 32'h21, 0);
    do_op("v2_slt", 4'b0100, 32'hFFFF_FFFF, 32'd1, 0);
    do_op("v2_sltu", 4'b0101, 32'hFFFF_FFFF, 32'd1, 0);
    do_op("v3_mul", 4'b1100, 32'hFFFF_FFFF, 32'd2, 0);
    do_op("v3_mulhu", 4'b1101, 32'hFFFF_FFFF, 32'd2, 0);
    do_op("v4_divu", 4'b1110, 32'd100, 32'd7, 0);
    do_op("v4_remu", 4'b1111, 32'd100, 32'd7, 0);
    do_op("v4_divu0", 4'b1110, 32'd9, 32'd0, 0);
    do_op("v4_remu0", 4'b1111, 32'd9, 32'd0, 0);
    do_op("v5_bp", 4'b0110, 32'h1234_5678, 32'h0F0F_0F0F, 10);
    do_op("pass0", 4'b0000, 32'hDEAD_BEEF, 32'd3, 0);
    do_op("pass11", 4'b1011, 32'hCAFE_F00D, 32'd3, 0);

    for (int i = 0; i < 40; i++) begin
      do_op($sformatf("rnd%0d", i), 4'($urandom), pick_operand(), pick_operand(),
            $urandom_range(0, 3));
    end

    // Reset during the tenth busy cycle of a multiply aborts it.
    in_valid = 1'b1;
    op_a     = 32'hFFFF_FFFF;
    op_b     = 32'd2;
    alu_ctrl = 4'b1100;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check("v6.ov", 64'(out_valid), 64'd0);
    check("v6.res", 64'(alu_result), 64'd0);
    check("v6.zero", 64'(zero), 64'd1);
    check("v6.rdy", 64'(in_ready), 64'd1);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check("v6.post_ov", 64'(out_valid), 64'd0);
    do_op("v6_add", 4'b0011, 32'd2, 32'd3, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_mc.md
ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width; SHALL be a power of two, 8..64.
REQ-002 clk  input  1  sole clock; all state SHALL update on rising edge.
REQ-003 reset  input  1  asynchronous, active-low; asserted (0) SHALL force reset state immediately, independent of clk.
REQ-004 in_valid  input  1  operation request present.
REQ-005 in_ready  output  1  block can accept an operation this cycle.
REQ-006 A, B  input  WIDTH each  operands, sampled only on acceptance.
REQ-007 ALU_control_in  input  4  operation code, sampled only on acceptance.
REQ-008 out_valid  output  1  ALU_result/zero hold a completed result.
REQ-009 out_ready  input  1  consumer takes the result this cycle.
REQ-010 ALU_result  output  WIDTH  registered result.
REQ-011 zero  output  1  registered; 1 iff ALU_result == 0.

Function
REQ-012 Acceptance SHALL occur on a rising edge with in_valid=1 and in_ready=1; operands and opcode are captured into internal registers.
REQ-013 Opcodes: 0011 add, 0010 sub, 0001 sll, 0110 xor, 0111 srl, 1001 or, 1010 and, 0100 slt (signed), 0101 sltu, 1000 sra, 1100 mul (low WIDTH bits), 1101 mulhu (high WIDTH bits, unsigned), 1110 divu, 1111 remu; 0000 and 1011 SHALL pass A unchanged.
REQ-014 Shift amount SHALL be B[log2(WIDTH)-1:0]; upper B bits ignored.
REQ-015 add/sub/mul SHALL wrap modulo 2^WIDTH; no overflow flag.
REQ-016 slt/sltu SHALL return 1 or 0 zero-extended to WIDTH.
REQ-017 divu by zero SHALL return all ones; remu by zero SHALL return A.
REQ-018 FSM states IDLE, BUSY, DONE; reset state IDLE.
REQ-019 IDLE: in_ready=1, out_valid=0; on acceptance of a single-cycle op (all except 1100-1111) SHALL go to DONE with result registered at that edge (out_valid one cycle after acceptance).
REQ-020 IDLE: on acceptance of 1100-1111 SHALL go to BUSY, load iteration counter with WIDTH.
REQ-021 BUSY: in_ready=0, out_valid=0; one shift-add (mul/mulhu) or restoring-subtract (divu/remu) step per cycle; counter decrements; at count 1 the final step SHALL register the result and go to DONE; result visible exactly WIDTH+1 cycles after acceptance.
REQ-022 Divide-by-zero SHALL still take the full WIDTH iterations (fixed latency).
REQ-023 DONE: in_ready=0, out_valid=1; ALU_result and zero SHALL hold stable until out_ready=1, then return to IDLE at that edge.
REQ-024 in_valid while in_ready=0 SHALL be ignored; requester holds request until accepted.
REQ-025 A, B, ALU_control_in changes during BUSY/DONE SHALL not affect the in-flight result.
REQ-026 zero SHALL be computed from the final registered result for every opcode (not forced 0).

Reset
REQ-027 While reset=0: state=IDLE, counter=0, ALU_result=0, zero=1, out_valid=0, in_ready=1 (asserted once reset releases); in-flight operation SHALL be discarded.
REQ-028 Reset asserted mid-BUSY or in DONE SHALL abort without producing out_valid; first acceptance after release behaves as from power-up.
REQ-029 Reset release SHALL be synchronised externally; no acceptance on the release edge is required.

Verification
V-1 WIDTH=32: add A=0x7FFFFFFF,B=1 -> ALU_result=0x80000000, zero=0, out_valid one cycle after acceptance; sub A=5,B=5 -> 0, zero=1.
V-2 sra A=0x80000000,B=0x21 -> shift 1, 0xC0000000; srl same -> 0x40000000; slt A=0xFFFFFFFF,B=1 -> 1; sltu -> 0.
V-3 mul A=0xFFFFFFFF,B=2 -> 0xFFFFFFFE; mulhu same -> 0x00000001; out_valid exactly 33 cycles after acceptance, in_ready=0 throughout.
V-4 divu A=100,B=7 -> 14; remu -> 2; divu A=9,B=0 -> 0xFFFFFFFF; remu A=9,B=0 -> 9, latency 33.
V-5 Backpressure: out_ready=0 for 10 cycles in DONE -> result stable, in_ready=0, new in_valid ignored; out_ready=1 -> IDLE next edge.
V-6 reset=0 asserted at BUSY cycle 10 of mul -> out_valid=0, ALU_result=0, zero=1 immediately; after release add 2+3 -> 5.
